// File: rtl/iexu_result_stage_pkg.sv
// Shared types for the EX result stage: result-source select, the buffered
// result record and the occupancy encodings of the skid buffer.
package iexu_result_stage_pkg;

    // Project-wide datapath word width (the codebase's data_size).
    localparam int DATA_SIZE  = 32;
    localparam int RADDR_SIZE = 5;

    typedef enum logic [1:0] {
        SEL_LOGIC = 2'd0,
        SEL_ADD   = 2'd1,
        SEL_SHIFT = 2'd2,
        SEL_SLT   = 2'd3
    } res_sel_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0]  data;
        logic [RADDR_SIZE-1:0] rd;
        logic                  we;
    } ex_result_t;

    // Occupancy encoding {skid.valid, main.valid}.
    localparam logic [1:0] OCC_EMPTY = 2'b00;
    localparam logic [1:0] OCC_ONE   = 2'b01;
    localparam logic [1:0] OCC_TWO   = 2'b11;

endpackage

// File: rtl/iexu_result_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush. Output comes only from
// MAIN; in_ready is a pure register decode so it never sees out_ready.
module result_skid_buf
    import iexu_result_stage_pkg::*;
#(
    parameter type T = ex_result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data,
    output logic drain
);

    logic main_valid_reg;
    logic skid_valid_reg;
    T     main_data_reg;
    T     skid_data_reg;
    logic accept;
    logic [1:0] occ;

    assign occ       = {skid_valid_reg, main_valid_reg};
    assign in_ready  = !skid_valid_reg;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid_reg & out_ready;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
        end else if (flush) begin
            // A drain this cycle still completes; the counter sees it via drain.
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_valid_reg <= 1'b1;
                        main_data_reg  <= in_data;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        main_data_reg <= in_data;
                    end else if (accept) begin
                        skid_valid_reg <= 1'b1;
                        skid_data_reg  <= in_data;
                    end else if (drain) begin
                        main_valid_reg <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    if (drain) begin
                        main_data_reg  <= skid_data_reg;
                        skid_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    // SKID without MAIN is unreachable; recover to empty.
                    main_valid_reg <= 1'b0;
                    skid_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/iexu_result_stage.sv
// EX result stage: selects one functional-unit result, buffers it toward MEM,
// taps it for forwarding and counts results handed over.
module iexu_result_stage
    import iexu_result_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_SIZE,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         res_sel,
    input  logic [DATA_W-1:0]  logic_res,
    input  logic [DATA_W-1:0]  add_res,
    input  logic [DATA_W-1:0]  shift_res,
    input  logic               slt_res,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               rd_we,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_we,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]   retired_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [RADDR_W-1:0] rd;
        logic               we;
    } payload_t;

    logic [DATA_W-1:0] sel_data;
    payload_t          in_payload;
    payload_t          out_payload;
    logic              drain;
    logic [CNT_W-1:0]  cnt_reg;

    always_comb begin
        sel_data = '0;
        case (res_sel)
            SEL_LOGIC: sel_data = logic_res;
            SEL_ADD:   sel_data = add_res;
            SEL_SHIFT: sel_data = shift_res;
            SEL_SLT:   sel_data = {{(DATA_W-1){1'b0}}, slt_res};
            default:   sel_data = '0;
        endcase
    end

    assign in_payload = '{data: sel_data, rd: rd_addr, we: rd_we};

    result_skid_buf #(.T(payload_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload),
        .drain     (drain)
    );

    assign out_data = out_payload.data;
    assign out_rd   = out_payload.rd;
    assign out_we   = out_payload.we;

    // x0 writes still go to MEM, but must never be forwarded.
    assign fwd_valid = out_valid & out_we & (out_rd != '0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (drain) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_iexu_result_stage.sv
// Directed bench for iexu_result_stage with hand-computed expectations.
module tb_iexu_result_stage;
    import iexu_result_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    res_sel;
    logic [DW-1:0] logic_res;
    logic [DW-1:0] add_res;
    logic [DW-1:0] shift_res;
    logic          slt_res;
    logic [RW-1:0] rd_addr;
    logic          rd_we;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          out_we;
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] retired_cnt;

    int checks = 0;
    int failures = 0;

    iexu_result_stage #(.DATA_W(DW), .RADDR_W(RW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .res_sel     (res_sel),
        .logic_res   (logic_res),
        .add_res     (add_res),
        .shift_res   (shift_res),
        .slt_res     (slt_res),
        .rd_addr     (rd_addr),
        .rd_we       (rd_we),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [1:0] sel, input logic [DW-1:0] val,
                           input logic [RW-1:0] rd, input logic we);
        in_valid  = 1'b1;
        res_sel   = sel;
        logic_res = (sel == SEL_LOGIC) ? val : 32'hDEAD_0001;
        add_res   = (sel == SEL_ADD)   ? val : 32'hDEAD_0002;
        shift_res = (sel == SEL_SHIFT) ? val : 32'hDEAD_0003;
        rd_addr   = rd;
        rd_we     = we;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; res_sel = SEL_LOGIC; logic_res = '0;
        add_res = '0; shift_res = '0; slt_res = 1'b0; rd_addr = '0;
        rd_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_retired", retired_cnt, 0);
        rst = 1'b0;
        tick();

        // 1: single transfer
        present(SEL_LOGIC, 32'hF0F0, 5'd3, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 32'hF0F0);
        chk("t1_fwd_valid", fwd_valid, 1);
        chk("t1_fwd_rd", fwd_rd, 3);
        chk("t1_fwd_data", fwd_data, 32'hF0F0);
        chk("t1_retired_before", retired_cnt, 0);
        tick();
        chk("t1_retired", retired_cnt, 1);
        chk("t1_empty", out_valid, 0);

        // 2: backpressure and ordering
        out_ready = 1'b0;
        present(SEL_ADD, 32'h11, 5'd1, 1'b1);
        tick();
        chk("t2_ready_one", in_ready, 1);
        chk("t2_a_data", out_data, 32'h11);
        present(SEL_SHIFT, 32'h22, 5'd2, 1'b1);
        tick();
        chk("t2_ready_two", in_ready, 0);
        chk("t2_a_hold", out_data, 32'h11);
        present(SEL_ADD, 32'h33, 5'd4, 1'b1);
        tick();
        chk("t2_c_blocked", in_ready, 0);
        chk("t2_a_stable", out_data, 32'h11);
        chk("t2_a_rd", out_rd, 1);
        out_ready = 1'b1;
        tick();
        chk("t2_ready_back", in_ready, 1);
        chk("t2_b_data", out_data, 32'h22);
        chk("t2_b_rd", out_rd, 2);
        tick();
        in_valid = 1'b0;
        chk("t2_c_data", out_data, 32'h33);
        chk("t2_c_rd", out_rd, 4);
        tick();
        chk("t2_drained", out_valid, 0);
        chk("t2_retired", retired_cnt, 4);

        // 3: SLT zero-extension
        out_ready = 1'b0;
        present(SEL_SLT, 32'h0, 5'd6, 1'b1);
        add_res = 32'hFFFF_FFFF;
        slt_res = 1'b1;
        tick();
        in_valid = 1'b0;
        slt_res = 1'b0;
        chk("t3_valid", out_valid, 1);
        chk("t3_slt_data", out_data, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("t3_retired", retired_cnt, 5);

        // 4: flush in TWO with a concurrent input
        out_ready = 1'b0;
        present(SEL_ADD, 32'h44, 5'd5, 1'b1);
        tick();
        present(SEL_ADD, 32'h55, 5'd5, 1'b1);
        tick();
        chk("t4_two", in_ready, 0);
        present(SEL_ADD, 32'h66, 5'd5, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t4_out_valid", out_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_retired", retired_cnt, 5);
        out_ready = 1'b1;
        tick();
        tick();
        chk("t4_no_ghost", out_valid, 0);
        chk("t4_retired_hold", retired_cnt, 5);

        // 5: write to x0, and a non-writing result
        present(SEL_LOGIC, 32'h77, 5'd0, 1'b1);
        tick();
        present(SEL_LOGIC, 32'h88, 5'd7, 1'b0);
        chk("t5_x0_we", out_we, 1);
        chk("t5_x0_rd", out_rd, 0);
        chk("t5_x0_fwd", fwd_valid, 0);
        chk("t5_x0_valid", out_valid, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_nowe_we", out_we, 0);
        chk("t5_nowe_fwd", fwd_valid, 0);
        chk("t5_nowe_data", out_data, 32'h88);
        tick();
        chk("t5_retired", retired_cnt, 7);

        // 6: counter wrap from a clean reset, then async reset in TWO
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cnt", retired_cnt, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            present(SEL_ADD, 32'(i + 100), 5'd9, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        chk("t6_last_data", out_data, 32'd116);
        tick();
        chk("t6_wrap", retired_cnt, 1);
        chk("t6_empty", out_valid, 0);

        out_ready = 1'b0;
        present(SEL_ADD, 32'hAA, 5'd10, 1'b1);
        tick();
        present(SEL_ADD, 32'hBB, 5'd11, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6_two", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ar_valid", out_valid, 0);
        chk("t6_ar_data", out_data, 0);
        chk("t6_ar_rd", out_rd, 0);
        chk("t6_ar_we", out_we, 0);
        chk("t6_ar_fwd_valid", fwd_valid, 0);
        chk("t6_ar_fwd_data", fwd_data, 0);
        chk("t6_ar_cnt", retired_cnt, 0);
        chk("t6_ar_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t6_post_valid", out_valid, 0);
        chk("t6_post_cnt", retired_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iexu_result_stage.md
Name: iexu_result_stage

Overview:
- Downstream neighbour of the integer logic unit: registers the EX-stage result and presents it to the MEM stage.
- Each cycle it selects one functional-unit result: logic unit, adder, shifter or set-less-than.
- Accepts over a valid/ready handshake behind a 2-entry skid buffer, so upstream ready never combinationally depends on downstream ready.
- Drives a forwarding port back to operand select and keeps a retired-result counter.

Parameters:
- DATA_W, default `data_size: width of every datapath word.
- RADDR_W, default 5: destination register address width.
- CNT_W, default 32: width of the retired-result counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  EX result candidate valid
- in_ready  out  1  stage can accept this cycle
- res_sel  in  2  result source select, encoding from package
- logic_res  in  DATA_W  logic unit output
- add_res  in  DATA_W  adder output
- shift_res  in  DATA_W  shifter output
- slt_res  in  1  compare flag, zero-extended to DATA_W
- rd_addr  in  RADDR_W  destination register
- rd_we  in  1  write-back enable
- flush  in  1  kill all buffered and incoming results
- out_valid  out  1  result valid toward MEM
- out_ready  in  1  MEM accepts
- out_data  out  DATA_W  selected result
- out_rd  out  RADDR_W  destination
- out_we  out  1  write enable
- fwd_valid  out  1  equals out_valid & out_we & (out_rd != 0)
- fwd_rd  out  RADDR_W  equals out_rd
- fwd_data  out  DATA_W  equals out_data
- retired_cnt  out  CNT_W  count of results handed to MEM

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all valids 0, data/rd/we 0, retired_cnt 0. in_ready is 1 after reset.
- Result mux: combinational, ahead of capture.
  - SEL_LOGIC -> logic_res
  - SEL_ADD -> add_res
  - SEL_SHIFT -> shift_res
  - SEL_SLT -> {DATA_W-1 zeros, slt_res}
- Storage:
  - Two entries, MAIN and SKID, each holding {valid, data, rd, we}.
  - Outputs are driven only from MAIN; latency is 1 cycle from acceptance to out_valid.
- in_ready = !SKID.valid. It is registered state only and has no path from out_ready.
- Definitions: accept = in_valid & in_ready; drain = MAIN.valid & out_ready.
- State machine, encoded by occupancy:
  - EMPTY: MAIN and SKID both invalid.
  - ONE: MAIN valid only.
  - TWO: MAIN and SKID both valid.
- Transitions when flush = 0:
  - EMPTY, accept -> ONE (MAIN <= input).
  - ONE, accept & drain -> ONE (MAIN <= input).
  - ONE, accept & !drain -> TWO (SKID <= input).
  - ONE, !accept & drain -> EMPTY.
  - TWO, drain -> ONE (MAIN <= SKID). No accept is possible in TWO.
  - In all other cases, hold.
- Ordering: strict FIFO. SKID never overtakes MAIN.
- Flush:
  - Takes precedence over everything. Next state is EMPTY and any input presented that cycle is dropped.
  - If drain coincides with flush, that handoff counts as completed: MEM has sampled it and retired_cnt increments.
- retired_cnt:
  - Increments by 1 on every drain.
  - Wraps modulo 2^CNT_W with no saturation.
- Output stability: while out_valid = 1 and out_ready = 0, out_data/out_rd/out_we hold stable.
- Writes to x0: out_we passes through unchanged. Only fwd_valid masks rd = 0.
- Reset mid-operation: both entries cleared immediately (asynchronous). No partial result is emitted after rst deasserts.

Decomposition:
- Shared package (alongside constants.sv):
  - res_sel_t enum: SEL_LOGIC=0, SEL_ADD=1, SEL_SHIFT=2, SEL_SLT=3.
  - ex_result_t struct: data, rd, we.
- Sub-module result_skid_buf: the generic 2-entry valid/ready skid buffer over ex_result_t, with flush.
- The top level holds the mux, the forwarding taps and the counter.

Test Plan:
1. Reset, then a single transfer: in_valid=1, res_sel=SEL_LOGIC, logic_res=0xF0F0, rd=3, we=1, out_ready=1 -> next cycle out_valid=1, out_data=0xF0F0, fwd_valid=1, fwd_rd=3; following cycle retired_cnt=1.
2. Backpressure: out_ready=0, push A=0x11 then B=0x22 -> in_ready goes 0 after B. Third push C is not accepted. Raise out_ready -> outputs A, B, C in that order, none lost or duplicated, and in_ready returns to 1 after A drains.
3. SLT zero-extension: res_sel=SEL_SLT, slt_res=1, with add_res=0xFFFF_FFFF present -> out_data=0x1.
4. Flush in state TWO, asserted together with in_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, retired_cnt unchanged, and the flushed input never appears.
5. Write to x0: rd=0, we=1 -> out_we=1, fwd_valid=0.
6. Counter wrap and mid-stream reset: with CNT_W=4, drain 17 results -> retired_cnt=1. Then assert rst asynchronously mid-cycle while in state TWO -> all outputs read 0 immediately.
